multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Multi-cycle control FSM; the producer end of the ALU control interface (ALUctrl/ALUsrc/ImmOp/EQ).
//  Fetches an instruction, decodes it into ALU and datapath strobes, consumes ALU EQ for branches.
//  Sits between instruction/data memory handshakes and the datapath (regfile, ALU, PC register).
// PARAMETERS
//  DATA_WIDTH  32  datapath and immediate width
//  ADDR_WIDTH   5  register-file address width
// PORTS
//  clk        in   1           clock, rising edge
//  rst        in   1           asynchronous, active-high reset
//  instr_req  out  1           instruction fetch request
//  instr_valid in  1           instr valid; accepted only in FETCH
//  instr      in   32          RV32 instruction word
//  EQ         in   1           ALU equality flag (ALUop1 == ALUop2)
//  mem_ready  in   1           data-memory access complete
//  ALUctrl    out  3           000 add, 001 sub, 010 and, 011 or, 100 xor
//  ALUsrc     out  1           1: ALUop2 = ImmOp; 0: register operand
//  ImmOp      out  DATA_WIDTH  sign-extended immediate
//  rs1/rs2/rd out  ADDR_WIDTH  register addresses from the IR
//  RegWrite   out  1           regfile write strobe
//  ResultSrc  out  1           1: writeback from memory; 0: from ALUout
//  MemRead    out  1           data-memory read strobe
//  MemWrite   out  1           data-memory write strobe
//  PCsrc      out  1           1: PC <= PC+ImmOp; 0: PC <= PC+4
//  PC_en      out  1           PC update strobe
//  illegal    out  1           unsupported instruction flag
// BEHAVIOUR
//  States: FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK (plus TRAP, see CONFIGURATION).
//  Reset (async): state=FETCH, IR=0.
//   - While rst=1, every output is 0, including instr_req.
//  FETCH: instr_req=1; hold until instr_valid=1, then IR<=instr, ->DECODE.
//  DECODE: 1 cycle, ->EXECUTE.
//  From EXECUTE onward, ALUctrl/ALUsrc/ImmOp/rs*/rd are stable combinational decodes of the IR.
//  Supported: add sub and or xor (R); addi andi ori xori (I); lw sw; beq bne.
//   - lw/sw: ALUctrl=000, ALUsrc=1.
//   - beq/bne: ALUctrl=001, ALUsrc=0.
//  EXECUTE transitions:
//   - branch: PCsrc = EQ for beq, !EQ for bne; PC_en=1 -> FETCH.
//   - lw/sw: -> MEMORY.
//   - R/I: -> WRITEBACK.
//  MEMORY: MemRead (lw) or MemWrite (sw) held high until mem_ready=1 (unbounded stall).
//   - sw: PC_en=1 on the mem_ready cycle -> FETCH.
//   - lw: -> WRITEBACK.
//  WRITEBACK: RegWrite=1, ResultSrc=(lw), PC_en=1 -> FETCH.
//  RegWrite is suppressed when rd=0.
//  Latency with instr_valid and mem_ready both immediate: branch 3, R/I 4, sw 4, lw 5 cycles.
//  Strobes (RegWrite, MemWrite, PC_en) are high for exactly 1 cycle per instruction.
//  PCsrc is meaningful only while PC_en=1; it is 0 in every other cycle.
//  instr_valid outside FETCH is ignored; mem_ready outside MEMORY is ignored.
//  Reset mid-operation: any state -> FETCH; no strobe fires in the cycle after reset release.
//  ImmOp formats: I = instr[31:20]; S = {instr[31:25], instr[11:7]};
//   B = {instr[31], instr[7], instr[30:25], instr[11:8], 0}. All sign-extended to DATA_WIDTH.
// CONFIGURATION
//  Macro ILLEGAL_TRAP_EN.
//  Defined: an unsupported opcode/funct detected in DECODE -> TRAP.
//   - TRAP: illegal=1; all strobes 0; instr_req=0; exits only via rst.
//  Undefined: an unsupported instruction executes as a NOP.
//   - EXECUTE asserts PC_en=1 with PCsrc=0, then -> FETCH.
//   - illegal stays tied to 0.
// STRUCTURE
//  ctrl_pkg: state enum; ALUctrl codes (ALU_ADD..ALU_XOR); RV32 opcode/funct3/funct7 constants.
//  Sub-module imm_gen: combinational, IR -> ImmOp per format; testable standalone.
//  Top holds the state register, IR and the output decode.
// TESTING
//  addi x1,x0,5 (0x00500093):
//   -> ALUctrl=000, ALUsrc=1, ImmOp=5, rd=1; RegWrite=1 in cycle 4; PC_en=1 in the same cycle.
//  add x3,x1,x2 (0x002081B3):
//   -> ALUctrl=000, ALUsrc=0, rs1=1, rs2=2; RegWrite=1, ResultSrc=0.
//  beq x1,x2,8 (0x00208463), EQ=1, then EQ=0:
//   -> ImmOp=8, ALUctrl=001; PCsrc=1 then 0; PC_en in cycle 3; RegWrite never set.
//  lw x5,8(x1) (0x0080A283), mem_ready held low 3 cycles:
//   -> MemRead high 4 cycles; then WRITEBACK with RegWrite=1, ResultSrc=1 (latency 8).
//  sw x2,4(x1) (0x0020A223), rst pulsed during MEMORY:
//   -> MemWrite drops immediately; state=FETCH; no RegWrite or PC_en.
//  0xFFFFFFFF:
//   -> with ILLEGAL_TRAP_EN: illegal=1, instr_req stays 0;
//   -> without it: PC_en=1 with PCsrc=0, back in FETCH.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types and RV32 encoding constants for the multi-cycle controller.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEMORY,
    S_WRITEBACK,
    S_TRAP
  } state_t;

  typedef enum logic [2:0] {
    K_ALU_R,
    K_ALU_I,
    K_LOAD,
    K_STORE,
    K_BRANCH,
    K_ILLEGAL
  } kind_t;

  typedef struct packed {
    kind_t      kind;
    logic [2:0] alu_ctrl;
  } dec_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  function automatic logic [2:0] alu_of(input logic [2:0] funct3);
    case (funct3)
      F3_XOR:  return ALU_XOR;
      F3_OR:   return ALU_OR;
      F3_AND:  return ALU_AND;
      default: return ALU_ADD;
    endcase
  endfunction

  // Anything not matched below stays K_ILLEGAL with an add encoding.
  function automatic dec_t decode(input logic [6:0] opcode, input logic [2:0] funct3,
                                  input logic [6:0] funct7);
    dec_t d;
    d.kind     = K_ILLEGAL;
    d.alu_ctrl = ALU_ADD;
    case (opcode)
      OP_R: begin
        if (funct7 == F7_SUB && funct3 == F3_ADD) begin
          d.kind     = K_ALU_R;
          d.alu_ctrl = ALU_SUB;
        end else if (funct7 == F7_BASE && funct3 inside {F3_ADD, F3_XOR, F3_OR, F3_AND}) begin
          d.kind     = K_ALU_R;
          d.alu_ctrl = alu_of(funct3);
        end
      end
      OP_I: begin
        if (funct3 inside {F3_ADD, F3_XOR, F3_OR, F3_AND}) begin
          d.kind     = K_ALU_I;
          d.alu_ctrl = alu_of(funct3);
        end
      end
      OP_LOAD:  if (funct3 == F3_W) d.kind = K_LOAD;
      OP_STORE: if (funct3 == F3_W) d.kind = K_STORE;
      OP_BRANCH: begin
        if (funct3 == F3_BEQ || funct3 == F3_BNE) begin
          d.kind     = K_BRANCH;
          d.alu_ctrl = ALU_SUB;
        end
      end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: selects the I/S/B field layout from the opcode and
// sign-extends it to DATA_WIDTH. Formats without an immediate yield zero.
module imm_gen
  import ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [31:0]           ir,
  output logic [DATA_WIDTH-1:0] imm
);

  logic [12:0] raw;
  logic        unused_fields;

  assign unused_fields = ^ir[19:12];

  always_comb begin
    raw = '0;
    case (ir[6:0])
      OP_I, OP_LOAD: raw = {ir[31], ir[31:20]};
      OP_STORE:      raw = {ir[31], ir[31:25], ir[11:7]};
      OP_BRANCH:     raw = {ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      default:       raw = '0;
    endcase
  end

  assign imm = {{(DATA_WIDTH-13){raw[12]}}, raw};

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32 subset control FSM driving ALU and datapath strobes.
// Build option: define ILLEGAL_TRAP_EN to lock up in TRAP on unsupported instructions.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  instr_req,
  input  logic                  instr_valid,
  input  logic [31:0]           instr,
  input  logic                  EQ,
  input  logic                  mem_ready,
  output logic [2:0]            ALUctrl,
  output logic                  ALUsrc,
  output logic [DATA_WIDTH-1:0] ImmOp,
  output logic [ADDR_WIDTH-1:0] rs1,
  output logic [ADDR_WIDTH-1:0] rs2,
  output logic [ADDR_WIDTH-1:0] rd,
  output logic                  RegWrite,
  output logic                  ResultSrc,
  output logic                  MemRead,
  output logic                  MemWrite,
  output logic                  PCsrc,
  output logic                  PC_en,
  output logic                  illegal
);

  state_t                state_reg;
  logic [31:0]           ir_reg;
  dec_t                  dec;
  logic [DATA_WIDTH-1:0] imm;
  logic                  rd_nonzero;

  assign dec        = decode(ir_reg[6:0], ir_reg[14:12], ir_reg[31:25]);
  assign rd_nonzero = (ir_reg[11:7] != 5'd0);

  imm_gen #(.DATA_WIDTH(DATA_WIDTH)) u_imm_gen (
    .ir  (ir_reg),
    .imm (imm)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_FETCH;
      ir_reg    <= '0;
    end else begin
      case (state_reg)
        S_FETCH: begin
          if (instr_valid) begin
            ir_reg    <= instr;
            state_reg <= S_DECODE;
          end
        end
`ifdef ILLEGAL_TRAP_EN
        S_DECODE: state_reg <= (dec.kind == K_ILLEGAL) ? S_TRAP : S_EXECUTE;
`else
        S_DECODE: state_reg <= S_EXECUTE;
`endif
        S_EXECUTE: begin
          case (dec.kind)
            K_LOAD, K_STORE:  state_reg <= S_MEMORY;
            K_ALU_R, K_ALU_I: state_reg <= S_WRITEBACK;
            default:          state_reg <= S_FETCH;
          endcase
        end
        S_MEMORY: begin
          if (mem_ready) state_reg <= (dec.kind == K_LOAD) ? S_WRITEBACK : S_FETCH;
        end
        S_WRITEBACK: state_reg <= S_FETCH;
        S_TRAP:      state_reg <= S_TRAP;
        default:     state_reg <= S_FETCH;
      endcase
    end
  end

  // Outputs are forced low while rst is held, even though state already reads FETCH.
  always_comb begin
    instr_req = 1'b0;
    ALUctrl   = '0;
    ALUsrc    = 1'b0;
    ImmOp     = '0;
    rs1       = '0;
    rs2       = '0;
    rd        = '0;
    RegWrite  = 1'b0;
    ResultSrc = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    PCsrc     = 1'b0;
    PC_en     = 1'b0;
    illegal   = 1'b0;
    if (!rst) begin
      ALUctrl = dec.alu_ctrl;
      ALUsrc  = dec.kind inside {K_ALU_I, K_LOAD, K_STORE};
      ImmOp   = imm;
      rs1     = ADDR_WIDTH'(ir_reg[19:15]);
      rs2     = ADDR_WIDTH'(ir_reg[24:20]);
      rd      = ADDR_WIDTH'(ir_reg[11:7]);
      case (state_reg)
        S_FETCH: instr_req = 1'b1;
        S_EXECUTE: begin
          if (dec.kind == K_BRANCH) begin
            PC_en = 1'b1;
            PCsrc = (ir_reg[14:12] == F3_BNE) ? !EQ : EQ;
          end else if (dec.kind == K_ILLEGAL) begin
            PC_en = 1'b1;
          end
        end
        S_MEMORY: begin
          MemRead  = (dec.kind == K_LOAD);
          MemWrite = (dec.kind == K_STORE);
          PC_en    = (dec.kind == K_STORE) && mem_ready;
        end
        S_WRITEBACK: begin
          RegWrite  = rd_nonzero;
          ResultSrc = (dec.kind == K_LOAD);
          PC_en     = 1'b1;
        end
`ifdef ILLEGAL_TRAP_EN
        S_TRAP: illegal = 1'b1;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: a per-cycle expectation built from the
// instruction class and handshake timing, checked every negedge.
module tb_multicycle_ctrl;

  logic        clk;
  logic        rst;
  logic        instr_req;
  logic        instr_valid;
  logic [31:0] instr;
  logic        EQ;
  logic        mem_ready;
  logic [2:0]  ALUctrl;
  logic        ALUsrc;
  logic [31:0] ImmOp;
  logic [4:0]  rs1, rs2, rd;
  logic        RegWrite, ResultSrc, MemRead, MemWrite, PCsrc, PC_en, illegal;

  multicycle_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .instr_req(instr_req), .instr_valid(instr_valid),
    .instr(instr), .EQ(EQ), .mem_ready(mem_ready), .ALUctrl(ALUctrl),
    .ALUsrc(ALUsrc), .ImmOp(ImmOp), .rs1(rs1), .rs2(rs2), .rd(rd),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .MemRead(MemRead),
    .MemWrite(MemWrite), .PCsrc(PCsrc), .PC_en(PC_en), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction classes used by the model.
  localparam int C_R = 0, C_I = 1, C_LD = 2, C_ST = 3, C_BR = 4, C_ILL = 5;
  localparam logic [31:0] JUNK = 32'h00F00093;
`ifdef ILLEGAL_TRAP_EN
  localparam int ILL_LAT = 0;
`else
  localparam int ILL_LAT = 3;
`endif

  typedef struct {
    logic [31:0] mask;
    logic [31:0] match;
    logic [2:0]  alu;
    bit          src;
    int          cls;
    bit          inv;
  } op_t;
  op_t ops[13];

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc_idx = 0;
  int pce_cycle = 0;
  bit chk_en = 0;
  bit dec_chk = 0;
  logic e_req, e_rw, e_rsrc, e_mr, e_mw, e_pcs, e_pce, e_ill;
  logic [2:0]  e_alu;
  logic        e_src;
  logic [31:0] e_imm;
  logic [4:0]  e_rs1, e_rs2, e_rd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc_idx, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("instr_req", 32'(instr_req), 32'(e_req));
      chk("RegWrite",  32'(RegWrite),  32'(e_rw));
      chk("ResultSrc", 32'(ResultSrc), 32'(e_rsrc));
      chk("MemRead",   32'(MemRead),   32'(e_mr));
      chk("MemWrite",  32'(MemWrite),  32'(e_mw));
      chk("PCsrc",     32'(PCsrc),     32'(e_pcs));
      chk("PC_en",     32'(PC_en),     32'(e_pce));
      chk("illegal",   32'(illegal),   32'(e_ill));
      if (dec_chk) begin
        chk("ALUctrl", 32'(ALUctrl), 32'(e_alu));
        chk("ALUsrc",  32'(ALUsrc),  32'(e_src));
        chk("ImmOp",   ImmOp,        e_imm);
        chk("rs1",     32'(rs1),     32'(e_rs1));
        chk("rs2",     32'(rs2),     32'(e_rs2));
        chk("rd",      32'(rd),      32'(e_rd));
      end
      if (PC_en) pce_cycle = cyc_idx;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_clear();
    e_req = 0; e_rw = 0; e_rsrc = 0; e_mr = 0; e_mw = 0; e_pcs = 0; e_pce = 0; e_ill = 0;
    dec_chk = 0;
  endtask

  // Reset view: all outputs, including the IR-derived fields, read zero.
  task automatic exp_zero();
    exp_clear();
    dec_chk = 1;
    e_alu = 0; e_src = 0; e_imm = 0; e_rs1 = 0; e_rs2 = 0; e_rd = 0;
  endtask

  function automatic int model_imm(input int cls, input logic [31:0] w);
    int v;
    v = 0;
    if (cls == C_I || cls == C_LD) begin
      v = int'(w[31:20]);
      if (w[31]) v -= 4096;
    end else if (cls == C_ST) begin
      v = int'({w[31:25], w[11:7]});
      if (w[31]) v -= 4096;
    end else if (cls == C_BR) begin
      v = int'({w[31], w[7], w[30:25], w[11:8], 1'b0});
      if (w[31]) v -= 8192;
    end
    return v;
  endfunction

  task automatic run(input string nm, input logic [31:0] w, input bit eq, input int fwait,
                     input int mwait, input bit rst_mid, input int exp_lat,
                     input logic [31:0] exp_imm);
    int  cls, n;
    logic [2:0] alu;
    bit  src, inv, aborted;
    cls = C_ILL; alu = 0; src = 0; inv = 0; aborted = 0;
    for (int k = 0; k < 13; k++)
      if ((w & ops[k].mask) == ops[k].match) begin
        cls = ops[k].cls; alu = ops[k].alu; src = ops[k].src; inv = ops[k].inv;
      end
    pce_cycle = 0;
    EQ = eq;
    mem_ready = 1;
    for (int i = 0; i < fwait; i++) begin
      instr_valid = 0; instr = w;
      exp_clear(); e_req = 1; cyc_idx = 0;
      step();
    end
    instr_valid = 1; instr = w;
    exp_clear(); e_req = 1; cyc_idx = 1;
    step();
    instr = JUNK;
    exp_clear(); cyc_idx = 2;
    step();
`ifdef ILLEGAL_TRAP_EN
    if (cls == C_ILL) begin
      for (int i = 0; i < 3; i++) begin
        exp_clear(); e_ill = 1; cyc_idx = 3 + i;
        step();
      end
      rst = 1; exp_zero();
      step();
      rst = 0; instr_valid = 0; exp_clear(); e_req = 1; cyc_idx = 0;
      step();
      aborted = 1;
    end
`endif
    if (!aborted) begin
      exp_clear();
      dec_chk = 1; e_alu = alu; e_src = src; e_imm = 32'(model_imm(cls, w));
      e_rs1 = w[19:15]; e_rs2 = w[24:20]; e_rd = w[11:7];
      if (cls == C_BR) begin e_pce = 1; e_pcs = eq ^ inv; end
      if (cls == C_ILL) e_pce = 1;
      cyc_idx = 3;
      step();
      n = 4;
      if (cls == C_LD || cls == C_ST) begin
        for (int i = 0; i <= mwait; i++) begin
          if (rst_mid && i == 1) begin
            rst = 1; exp_zero(); cyc_idx = n;
            step();
            rst = 0; instr_valid = 0; exp_clear(); e_req = 1; cyc_idx = 0;
            step();
            aborted = 1;
            break;
          end
          mem_ready = (i == mwait);
          e_mr = (cls == C_LD); e_mw = (cls == C_ST);
          e_pce = (cls == C_ST) && (i == mwait);
          cyc_idx = n; n++;
          step();
        end
        mem_ready = 1;
      end
      if (!aborted && (cls == C_R || cls == C_I || cls == C_LD)) begin
        e_mr = 0; e_mw = 0;
        e_rw = (w[11:7] != 0); e_rsrc = (cls == C_LD); e_pce = 1;
        cyc_idx = n;
        step();
      end
    end
    instr_valid = 0;
    chk({"latency ", nm}, 32'(pce_cycle), 32'(exp_lat));
    chk({"imm_lit ", nm}, ImmOp, exp_imm);
    $display("txn %-6s instr=%h lat=%0d imm=%h", nm, w, pce_cycle, ImmOp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc_idx);
    $fatal(1, "watchdog");
  end

  initial begin
    ops[0]  = '{32'hFE00707F, 32'h00000033, 3'd0, 1'b0, C_R,  1'b0}; // add
    ops[1]  = '{32'hFE00707F, 32'h40000033, 3'd1, 1'b0, C_R,  1'b0}; // sub
    ops[2]  = '{32'hFE00707F, 32'h00007033, 3'd2, 1'b0, C_R,  1'b0}; // and
    ops[3]  = '{32'hFE00707F, 32'h00006033, 3'd3, 1'b0, C_R,  1'b0}; // or
    ops[4]  = '{32'hFE00707F, 32'h00004033, 3'd4, 1'b0, C_R,  1'b0}; // xor
    ops[5]  = '{32'h0000707F, 32'h00000013, 3'd0, 1'b1, C_I,  1'b0}; // addi
    ops[6]  = '{32'h0000707F, 32'h00007013, 3'd2, 1'b1, C_I,  1'b0}; // andi
    ops[7]  = '{32'h0000707F, 32'h00006013, 3'd3, 1'b1, C_I,  1'b0}; // ori
    ops[8]  = '{32'h0000707F, 32'h00004013, 3'd4, 1'b1, C_I,  1'b0}; // xori
    ops[9]  = '{32'h0000707F, 32'h00002003, 3'd0, 1'b1, C_LD, 1'b0}; // lw
    ops[10] = '{32'h0000707F, 32'h00002023, 3'd0, 1'b1, C_ST, 1'b0}; // sw
    ops[11] = '{32'h0000707F, 32'h00000063, 3'd1, 1'b0, C_BR, 1'b0}; // beq
    ops[12] = '{32'h0000707F, 32'h00001063, 3'd1, 1'b0, C_BR, 1'b1}; // bne
    rst = 1; instr_valid = 1; instr = JUNK; EQ = 1; mem_ready = 1;
    #1;
    exp_zero();
    chk_en = 1;
    step();
    step();
    rst = 0;
    run("addi",  32'h00500093, 1'b0, 1, 0, 1'b0, 4, 32'd5);
    run("add",   32'h002081B3, 1'b0, 0, 0, 1'b0, 4, 32'd0);
    run("beq1",  32'h00208463, 1'b1, 0, 0, 1'b0, 3, 32'd8);
    run("beq0",  32'h00208463, 1'b0, 2, 0, 1'b0, 3, 32'd8);
    run("bne0",  32'h00209463, 1'b0, 0, 0, 1'b0, 3, 32'd8);
    run("bneN",  32'hFE209EE3, 1'b1, 0, 0, 1'b0, 3, 32'hFFFFFFFC);
    run("sub",   32'h40208233, 1'b1, 0, 0, 1'b0, 4, 32'd0);
    run("and",   32'h0020F333, 1'b0, 0, 0, 1'b0, 4, 32'd0);
    run("or",    32'h0020E333, 1'b0, 0, 0, 1'b0, 4, 32'd0);
    run("ori",   32'h7FF0E393, 1'b0, 0, 0, 1'b0, 4, 32'd2047);
    run("andi",  32'hFF00F393, 1'b0, 0, 0, 1'b0, 4, 32'hFFFFFFF0);
    run("xorix0", 32'hFFF0C013, 1'b0, 0, 0, 1'b0, 4, 32'hFFFFFFFF);
    run("lw",    32'h0080A283, 1'b0, 0, 3, 1'b0, 8, 32'd8);
    run("lwx0",  32'hFFC0A003, 1'b0, 0, 0, 1'b0, 5, 32'hFFFFFFFC);
    run("sw",    32'h0020A223, 1'b0, 0, 0, 1'b0, 4, 32'd4);
    run("swrst", 32'h0020A223, 1'b0, 0, 2, 1'b1, 0, 32'd0);
    run("mul",   32'h022081B3, 1'b0, 0, 0, 1'b0, ILL_LAT, 32'd0);
    run("ones",  32'hFFFFFFFF, 1'b1, 0, 0, 1'b0, ILL_LAT, 32'd0);
    run("addi2", 32'h00500093, 1'b0, 0, 0, 1'b0, 4, 32'd5);
    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
